// File: rtl/popcount_sched.sv
// popcount_sched: two-requester nibble scheduler feeding a shared one-hot
// popcount unit. One owner at a time streams nibbles. The unit's one-hot
// results are summed into a saturating 8-bit total, which is reported on done.
// Optional feature: define POPCOUNT_SCHED_BURST_LIMIT_EN to end a burst on
// its 16th transfer even when last_x is low.
module popcount_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [3:0] data_a,
  input  logic [3:0] data_b,
  input  logic       last_a,
  input  logic       last_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [3:0] pc_data,
  input  logic [4:0] pc_onehot,
  output logic       done,
  output logic       done_id,
  output logic [7:0] done_count,
  output logic       err
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;
  logic [7:0] acc_q, acc_d;
  logic       done_id_q, done_id_d;
  logic [7:0] done_count_q, done_count_d;
  logic       err_q, err_d;
`ifdef POPCOUNT_SCHED_BURST_LIMIT_EN
  logic [3:0] xfer_cnt_q, xfer_cnt_d;
`endif

  logic       last_own;
  logic       xfer;
  logic       onehot_ok;
  logic       end_burst;
  logic [2:0] pc_val;
  logic [8:0] sum;
  logic [7:0] acc_sat;

  // Grants and the shared-unit operand come straight from the owner in BUSY
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    pc_data  = 4'h0;
    last_own = owner_q ? last_b : last_a;
    if (state_q == ST_BUSY) begin
      pc_data = owner_q ? data_b : data_a;
      gnt_a   = ena & req_a & ~owner_q;
      gnt_b   = ena & req_b & owner_q;
    end
    xfer = gnt_a | gnt_b;
  end

  // Decode the unit's one-hot result; anything malformed contributes zero
  always_comb begin
    onehot_ok = (pc_onehot != 5'b0) && ((pc_onehot & (pc_onehot - 5'd1)) == 5'b0);
    pc_val    = 3'd0;
    for (int n = 1; n < 5; n++) begin
      if (pc_onehot[n]) pc_val = 3'(n);
    end
    if (!onehot_ok) pc_val = 3'd0;
    sum     = {1'b0, acc_q} + {6'b0, pc_val};
    acc_sat = sum[8] ? 8'hFF : sum[7:0];
  end

`ifdef POPCOUNT_SCHED_BURST_LIMIT_EN
  assign end_burst = last_own | (xfer_cnt_q == 4'd15);
`else
  assign end_burst = last_own;
`endif

  assign done       = (state_q == ST_DONE) & ena;
  assign done_id    = done_id_q;
  assign done_count = done_count_q;
  assign err        = err_q;

  // Next-state logic: arbitration, accumulation and burst completion
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    acc_d        = acc_q;
    done_id_d    = done_id_q;
    done_count_d = done_count_q;
    err_d        = err_q;
`ifdef POPCOUNT_SCHED_BURST_LIMIT_EN
    xfer_cnt_d   = xfer_cnt_q;
`endif
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (req_a | req_b) begin
            // A lone requester wins; a tie goes to the round-robin pointer
            owner_d = (req_a & req_b) ? rr_q : req_b;
            acc_d   = 8'd0;
            state_d = ST_BUSY;
`ifdef POPCOUNT_SCHED_BURST_LIMIT_EN
            xfer_cnt_d = 4'd0;
`endif
          end
        end
        ST_BUSY: begin
          if (xfer) begin
            if (!onehot_ok) err_d = 1'b1;
            acc_d = acc_sat;
`ifdef POPCOUNT_SCHED_BURST_LIMIT_EN
            xfer_cnt_d = xfer_cnt_q + 4'd1;
`endif
            if (end_burst) begin
              state_d      = ST_DONE;
              done_count_d = acc_sat;
              done_id_d    = owner_q;
            end
          end
        end
        ST_DONE: begin
          rr_d    = ~owner_q;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; reset wins over ena
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      acc_q        <= 8'd0;
      done_id_q    <= 1'b0;
      done_count_q <= 8'd0;
      err_q        <= 1'b0;
`ifdef POPCOUNT_SCHED_BURST_LIMIT_EN
      xfer_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      acc_q        <= acc_d;
      done_id_q    <= done_id_d;
      done_count_q <= done_count_d;
      err_q        <= err_d;
`ifdef POPCOUNT_SCHED_BURST_LIMIT_EN
      xfer_cnt_q   <= xfer_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_popcount_sched.sv
// Testbench for popcount_sched: requester drivers push expected burst totals
// into per-requester queues; a monitor pops and compares on every done.
`timescale 1ns/1ps
module tb_popcount_sched;

`ifdef POPCOUNT_SCHED_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [3:0] data_a = 4'h0, data_b = 4'h0;
  logic       last_a = 1'b0, last_b = 1'b0;
  logic       gnt_a, gnt_b, done, done_id, err;
  logic [3:0] pc_data;
  logic [4:0] pc_onehot;
  logic [7:0] done_count;
  logic       corrupt = 1'b0;
  logic       prev_done = 1'b0;

  int tests = 0;
  int fails = 0;
  int exp_a[$];
  int exp_b[$];
  bit in_burst[2];

  always #5 clk = ~clk;

  // Behavioural one-hot popcount unit, with an injectable malformed result
  assign pc_onehot = corrupt ? 5'b00011 : 5'(32'd1 << $countones(pc_data));

  popcount_sched dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_a(req_a), .req_b(req_b), .data_a(data_a), .data_b(data_b),
    .last_a(last_a), .last_b(last_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .pc_data(pc_data), .pc_onehot(pc_onehot), .done(done),
    .done_id(done_id), .done_count(done_count), .err(err)
  );

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic set_req(input bit side, input logic r, input logic [3:0] d, input logic l);
    if (side) begin req_b = r; data_b = d; last_b = l; end
    else      begin req_a = r; data_a = d; last_a = l; end
  endtask

  // Monitor: scoreboard pop on done, single-pulse check, non-owner blocking
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (done_id) begin
        check("done_expected_b", int'(exp_b.size() > 0), 1);
        if (exp_b.size() > 0) check("sb_count_b", int'(done_count), exp_b.pop_front());
      end else begin
        check("done_expected_a", int'(exp_a.size() > 0), 1);
        if (exp_a.size() > 0) check("sb_count_a", int'(done_count), exp_a.pop_front());
      end
      check("done_one_cycle", int'(prev_done), 0);
    end
    if (rst_n && in_burst[0] && req_b) check("b_blocked", int'(gnt_b), 0);
    if (rst_n && in_burst[1] && req_a) check("a_blocked", int'(gnt_a), 0);
    prev_done = done;
  end

  // Drive one burst; the model sums ones per nibble (0 if corrupted),
  // saturates at 255 and closes a report on last (or every 16th with limit)
  task automatic run_burst(input bit side, input int len, input logic [3:0] nibs [80],
                           input int corrupt_idx, input int stall_idx, input int stall_len,
                           input bit rand_stall, input int hold_ena);
    int  sum = 0;
    int  cnt = 0;
    int  budget;
    int  stall;
    bit  g;
    for (int i = 0; i < len; i++) begin
      stall = (i == stall_idx) ? stall_len : 0;
      if (rand_stall && $urandom_range(3) == 0) stall = int'($urandom_range(4, 1));
      if (stall > 0) begin
        set_req(side, 1'b0, 4'h0, 1'b0);
        repeat (stall) @(posedge clk);
        #1;
      end
      set_req(side, 1'b1, nibs[i], i == len - 1);
      corrupt = (i == corrupt_idx);
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
        g = side ? gnt_b : gnt_a;
      end while (rst_n && !g && budget < 1000);
      if (!rst_n) break;
      if (!g) begin
        check(side ? "gnt_b_timeout" : "gnt_a_timeout", int'(g), 1);
        break;
      end
      in_burst[side] = 1'b1;
      sum = sum + ((i == corrupt_idx) ? 0 : $countones(nibs[i]));
      if (sum > 255) sum = 255;
      cnt++;
      @(posedge clk);
      #1;
      corrupt = 1'b0;
      if (i == len - 1 || (LIMIT && cnt == 16)) begin
        if (side) exp_b.push_back(sum); else exp_a.push_back(sum);
        in_burst[side] = 1'b0;
        if (i == len - 1) set_req(side, 1'b0, 4'h0, 1'b0);
        if (i == len - 1 && hold_ena > 0) begin
          ena = 1'b0;
          repeat (hold_ena) begin
            @(negedge clk);
            check("done_held_by_ena", int'(done), 0);
          end
          @(posedge clk);
          #1;
          ena = 1'b1;
        end
        @(negedge clk);
        check("done_latency", int'(done), 1);
        check("done_id", int'(done_id), int'(side));
        check("done_count", int'(done_count), sum);
        sum = 0;
        cnt = 0;
      end
    end
    corrupt = 1'b0;
    in_burst[side] = 1'b0;
    set_req(side, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic expect_first(input bit side);
    int b = 0;
    do begin @(negedge clk); b++; end while (!gnt_a && !gnt_b && b < 100);
    check("tie_first_grant", int'(side ? gnt_b : gnt_a), 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt_a", int'(gnt_a), 0);
    check("rst_gnt_b", int'(gnt_b), 0);
    check("rst_pc_data", int'(pc_data), 0);
    check("rst_done", int'(done), 0);
    check("rst_done_id", int'(done_id), 0);
    check("rst_done_count", int'(done_count), 0);
    check("rst_err", int'(err), 0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] na [80];
    logic [3:0] nb [80];

    // Reset asserted with ena low: reset still takes effect
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    #1;
    rst_n = 1'b1;
    ena = 1'b1;
    @(posedge clk);
    #1;

    // A burst F,F,1 -> 9, done one cycle after the last transfer
    na[0] = 4'hF; na[1] = 4'hF; na[2] = 4'h1;
    run_burst(1'b0, 3, na, -1, -1, 0, 1'b0, 0);
    repeat (3) @(posedge clk);

    // Tie from reset goes to A; B burst 5,last -> 2; next tie goes to A again
    do_reset();
    na[0] = 4'h3; na[1] = 4'h8;
    nb[0] = 4'h5;
    fork
      run_burst(1'b0, 2, na, -1, -1, 0, 1'b0, 0);
      run_burst(1'b1, 1, nb, -1, -1, 0, 1'b0, 0);
      expect_first(1'b0);
    join
    repeat (2) @(posedge clk);
    #1;
    fork
      run_burst(1'b0, 2, na, -1, -1, 0, 1'b0, 0);
      run_burst(1'b1, 1, nb, -1, -1, 0, 1'b0, 0);
      expect_first(1'b0);
    join
    repeat (3) @(posedge clk);

    // A drops req for 4 cycles mid-burst while B keeps requesting
    for (int i = 0; i < 6; i++) na[i] = 4'($urandom_range(15));
    nb[0] = 4'h7; nb[1] = 4'hA;
    fork
      run_burst(1'b0, 6, na, -1, 2, 4, 1'b0, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        run_burst(1'b1, 2, nb, -1, -1, 0, 1'b0, 0);
      end
    join
    repeat (3) @(posedge clk);

    // Malformed one-hot on one transfer of F,F -> total 4, err sticky
    @(negedge clk);
    check("err_clear_before", int'(err), 0);
    #1;
    na[0] = 4'hF; na[1] = 4'hF;
    run_burst(1'b0, 2, na, 1, -1, 0, 1'b0, 0);
    @(negedge clk);
    check("err_set", int'(err), 1);
    #1;
    nb[0] = 4'hC;
    run_burst(1'b1, 1, nb, -1, -1, 0, 1'b0, 0);
    @(negedge clk);
    check("err_sticky", int'(err), 1);
    #1;

    // 70 nibbles of F: saturates at 255 (or splits into 16-transfer bursts)
    for (int i = 0; i < 70; i++) na[i] = 4'hF;
    run_burst(1'b0, 70, na, -1, -1, 0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;

    // Randomized concurrent bursts with random stalls
    for (int it = 0; it < 8; it++) begin
      int la, lb;
      la = int'($urandom_range(20, 1));
      lb = int'($urandom_range(20, 1));
      for (int i = 0; i < 80; i++) begin
        na[i] = 4'($urandom_range(15));
        nb[i] = 4'($urandom_range(15));
      end
      fork
        run_burst(1'b0, la, na, -1, -1, 0, 1'b1, 0);
        run_burst(1'b1, lb, nb, -1, -1, 0, 1'b1, 0);
      join
      repeat (2) @(posedge clk);
      #1;
    end

    // ena low for 3 cycles on DONE entry delays done by 3 cycles
    na[0] = 4'h6; na[1] = 4'h9; na[2] = 4'hE;
    run_burst(1'b0, 3, na, -1, -1, 0, 1'b0, 3);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-burst (with ena low) discards the burst: no done, outputs 0
    for (int i = 0; i < 10; i++) na[i] = 4'hF;
    fork
      run_burst(1'b0, 10, na, -1, -1, 0, 1'b0, 0);
      begin
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        ena = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        #1;
        rst_n = 1'b1;
        ena = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sb_empty_a", exp_a.size(), 0);
    check("sb_empty_b", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/popcount_sched.md
POPCOUNT_SCHED -- requirements
Module: popcount_sched

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-003 SHALL have port ena, input, 1, global enable; low freezes all state and forces grants low.
REQ-004 SHALL have ports req_a / req_b, input, 1 each, requester A/B offers a nibble.
REQ-005 SHALL have ports data_a / data_b, input, 4 each, nibble offered by A/B.
REQ-006 SHALL have ports last_a / last_b, input, 1 each, offered nibble ends the burst.
REQ-007 SHALL have ports gnt_a / gnt_b, output, 1 each, nibble accepted this cycle.
REQ-008 SHALL have port pc_data, output, 4, nibble driven to the shared one-hot popcount unit.
REQ-009 SHALL have port pc_onehot, input, 5, unit result; bit n set means n ones (bit0=0 ... bit4=4).
REQ-010 SHALL have port done, output, 1, one-cycle pulse: burst total valid.
REQ-011 SHALL have port done_id, output, 1, owner of reported burst (0=A, 1=B); held until next done.
REQ-012 SHALL have port done_count, output, 8, burst ones total; held until next done.
REQ-013 SHALL have port err, output, 1, sticky: malformed pc_onehot seen.

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE.
REQ-015 IDLE: if ena and any req, SHALL latch owner and go BUSY next cycle; acc cleared to 0.
REQ-016 Owner selection: single requester wins; both requesting -> owner = round-robin pointer rr.
REQ-017 BUSY: gnt_owner SHALL be combinational = ena & req_owner; non-owner grant SHALL be 0.
REQ-018 pc_data SHALL equal data of owner in BUSY, 4'h0 otherwise.
REQ-019 Transfer = gnt & req same cycle; SHALL add decoded pc_onehot (0..4) to acc, saturating at 255.
REQ-020 Owner dropping req mid-burst SHALL stall BUSY without penalty or timeout; other requester stays blocked.
REQ-021 Transfer with last high SHALL move to DONE; done asserted the following cycle (1-cycle latency).
REQ-022 DONE: done=1 for exactly one cycle, done_count = final acc, done_id = owner, rr = ~owner; then IDLE.
REQ-023 No grant SHALL issue in DONE or IDLE; minimum burst-to-burst gap is 2 cycles.
REQ-024 pc_onehot not exactly one bit set during transfer SHALL add 0 and set err; err cleared only by reset.
REQ-025 ena low in any state SHALL hold state, acc, rr, outputs; a pending done SHALL be delayed, not lost.

Reset
REQ-026 On rising clk with rst_n=0: state IDLE, acc 0, rr 0 (A favoured), owner 0.
REQ-027 Reset values: gnt_a 0, gnt_b 0, pc_data 0, done 0, done_id 0, done_count 0, err 0.
REQ-028 Reset mid-burst SHALL discard the burst; no done issued for it.
REQ-029 Reset SHALL override ena.

Configuration
REQ-030 Macro POPCOUNT_SCHED_BURST_LIMIT_EN defined: 16th transfer of a burst SHALL be treated as last regardless of last_x.
REQ-031 With macro: forced termination reports normally; owner's next nibble starts a new arbitration.
REQ-032 Without macro: bursts unbounded; only last_x ends a burst; acc saturates per REQ-019.

Verification
REQ-033 Reset, A bursts 3 nibbles F,F,1 (last on third), model returns correct one-hot -> done one cycle later, done_id 0, done_count 9.
REQ-034 A and B request together from reset -> A granted first; B burst 5,last -> done_id 1, count 2; next tie grants A.
REQ-035 A drops req 4 cycles mid-burst while B requests -> gnt_b stays 0, A burst completes with correct total.
REQ-036 pc_onehot=5'b00011 on one transfer of burst F,F -> err=1 sticky, done_count 4.
REQ-037 A burst of 70 nibbles F -> done_count 255 (no macro); with POPCOUNT_SCHED_BURST_LIMIT_EN -> done after 16, count 64.
REQ-038 ena low for 3 cycles on DONE entry, rst_n low mid-burst -> done delayed 3 cycles; reset burst yields no done, outputs 0.
